// File: rtl/decode_pkg.sv
// Shared types and constants for the MIPS decode stage: field widths, format
// encoding, opcode constants and the fixed-width part of the decoded bundle.
package decode_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned FMT_W   = 2;

  typedef enum logic [FMT_W-1:0] {
    FMT_R = 2'd0,
    FMT_J = 2'd1,
    FMT_I = 2'd2
  } fmt_e;

  localparam logic [OP_W-1:0]  OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0]  OP_J     = 6'h02;
  localparam logic [OP_W-1:0]  OP_JAL   = 6'h03;
  localparam logic [REG_W-1:0] REG_RA   = 5'd31;

  // XLEN-independent fields; the stage wraps this with its XLEN-wide payload
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  shmt;
    logic [FUNC_W-1:0] func;
    fmt_e              fmt;
    logic [REG_W-1:0]  dst;
  } dec_fields_t;

  function automatic fmt_e classify(input logic [OP_W-1:0] op);
    if (op == OP_RTYPE) return FMT_R;
    if (op == OP_J || op == OP_JAL) return FMT_J;
    return FMT_I;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational MIPS field split: classification, destination register,
// immediate extension and absolute jump target at XLEN width.
module decode_fields
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [XLEN-1:0]    pc_i,
  output dec_fields_t        fields_c_o,
  output logic [XLEN-1:0]    imm_sext_c_o,
  output logic [XLEN-1:0]    imm_zext_c_o,
  output logic [XLEN-1:0]    jtarget_c_o
);

  logic [IMM_W-1:0] imm;
  logic [XLEN-1:0]  pc4;
  logic             unused_pc4_lo;

  always_comb begin
    fields_c_o        = '0;
    fields_c_o.opcode = instr_i[31:26];
    fields_c_o.rs     = instr_i[25:21];
    fields_c_o.rt     = instr_i[20:16];
    fields_c_o.rd     = instr_i[15:11];
    fields_c_o.shmt   = instr_i[10:6];
    fields_c_o.func   = instr_i[5:0];
    fields_c_o.fmt    = classify(instr_i[31:26]);
    fields_c_o.dst    = instr_i[20:16];
    case (instr_i[31:26])
      OP_RTYPE: fields_c_o.dst = instr_i[15:11];
      OP_JAL:   fields_c_o.dst = REG_RA;
      OP_J:     fields_c_o.dst = '0;
      default:  fields_c_o.dst = instr_i[20:16];
    endcase
  end

  assign imm          = instr_i[15:0];
  assign imm_sext_c_o = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zext_c_o = {{(XLEN-IMM_W){1'b0}}, imm};

  // Jump region comes from the wrapped PC+4; its low bits are replaced
  assign pc4           = pc_i + XLEN'(4);
  assign jtarget_c_o   = {pc4[XLEN-1:28], instr_i[25:0], 2'b00};
  assign unused_pc4_lo = ^pc4[27:0];

endmodule

// File: rtl/decode_stage.sv
// Registered MIPS decode stage with valid/ready handshake and flush.
// Define DECODE_SKID_EN for a one-entry skid buffer and a registered in_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_opcode,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rt,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_shmt,
  output logic [FUNC_W-1:0]  out_func,
  output logic [XLEN-1:0]    out_imm_sext,
  output logic [XLEN-1:0]    out_imm_zext,
  output logic [XLEN-1:0]    out_jtarget,
  output logic [FMT_W-1:0]   out_fmt,
  output logic [REG_W-1:0]   out_dst,
  output logic [XLEN-1:0]    out_pc
);

  typedef struct packed {
    dec_fields_t     f;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] imm_zext;
    logic [XLEN-1:0] jtarget;
    logic [XLEN-1:0] pc;
  } bundle_t;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  bundle_t         in_bundle, out_q, out_d;
  dec_fields_t     fields_c;
  logic [XLEN-1:0] imm_sext_c, imm_zext_c, jtarget_c;
  logic            accept, xfer, load_out;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .instr_i      (in_instr),
    .pc_i         (in_pc),
    .fields_c_o   (fields_c),
    .imm_sext_c_o (imm_sext_c),
    .imm_zext_c_o (imm_zext_c),
    .jtarget_c_o  (jtarget_c)
  );

  assign in_bundle = '{f: fields_c, imm_sext: imm_sext_c, imm_zext: imm_zext_c,
                       jtarget: jtarget_c, pc: in_pc};

`ifdef DECODE_SKID_EN
  logic    skid_valid_q, skid_valid_d, load_skid;
  bundle_t skid_q;
  assign in_ready = !skid_valid_q;
`else
  assign in_ready = (state_q == S_EMPTY) || out_ready;
`endif

  assign accept    = in_valid && in_ready;
  assign xfer      = (state_q == S_FULL) && out_ready;
  assign out_valid = (state_q == S_FULL);

  // Next state and load selects; skid drains into the output before new input
  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    out_d    = in_bundle;
`ifdef DECODE_SKID_EN
    skid_valid_d = skid_valid_q;
    load_skid    = 1'b0;
`endif
    if (flush) begin
      state_d = S_EMPTY;
`ifdef DECODE_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            load_out = 1'b1;
            state_d  = S_FULL;
          end
        end
        S_FULL: begin
`ifdef DECODE_SKID_EN
          if (!xfer) begin
            if (accept) begin
              load_skid    = 1'b1;
              skid_valid_d = 1'b1;
            end
          end else if (skid_valid_q) begin
            load_out     = 1'b1;
            out_d        = skid_q;
            load_skid    = accept;
            skid_valid_d = accept;
          end else if (accept) begin
            load_out = 1'b1;
          end else begin
            state_d = S_EMPTY;
          end
`else
          if (xfer) begin
            if (accept) load_out = 1'b1;
            else        state_d  = S_EMPTY;
          end
`endif
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      out_q   <= '{f: '0, imm_sext: '0, imm_zext: '0, jtarget: '0, pc: RESET_PC};
    end else begin
      state_q <= state_d;
      if (load_out) out_q <= out_d;
    end
  end

`ifdef DECODE_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      if (load_skid) skid_q <= in_bundle;
    end
  end
`endif

  assign out_opcode   = out_q.f.opcode;
  assign out_rs       = out_q.f.rs;
  assign out_rt       = out_q.f.rt;
  assign out_rd       = out_q.f.rd;
  assign out_shmt     = out_q.f.shmt;
  assign out_func     = out_q.f.func;
  assign out_fmt      = out_q.f.fmt;
  assign out_dst      = out_q.f.dst;
  assign out_imm_sext = out_q.imm_sext;
  assign out_imm_zext = out_q.imm_zext;
  assign out_jtarget  = out_q.jtarget;
  assign out_pc       = out_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: accepted instructions are queued and a
// monitor checks every presented bundle against an arithmetic decode model.
module tb_decode_stage;

  localparam int unsigned XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef DECODE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [5:0]  out_opcode, out_func;
  logic [4:0]  out_rs, out_rt, out_rd, out_shmt, out_dst;
  logic [31:0] out_imm_sext, out_imm_zext, out_jtarget, out_pc;
  logic [1:0]  out_fmt;

  decode_stage #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shmt(out_shmt), .out_func(out_func), .out_imm_sext(out_imm_sext),
    .out_imm_zext(out_imm_zext), .out_jtarget(out_jtarget), .out_fmt(out_fmt),
    .out_dst(out_dst), .out_pc(out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  item_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    done    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set rules, using plain arithmetic
  function automatic int unsigned m_op(input logic [31:0] i);  return i / 32'h0400_0000; endfunction
  function automatic int unsigned m_fld(input logic [31:0] i, input int sh);
    return (i >> sh) % 32;
  endfunction
  function automatic int unsigned m_fmt(input logic [31:0] i);
    if (m_op(i) == 0) return 0;
    if (m_op(i) == 2 || m_op(i) == 3) return 1;
    return 2;
  endfunction
  function automatic int unsigned m_dst(input logic [31:0] i);
    if (m_op(i) == 0) return m_fld(i, 11);
    if (m_op(i) == 3) return 31;
    if (m_op(i) == 2) return 0;
    return m_fld(i, 16);
  endfunction
  function automatic logic [31:0] m_sext(input logic [31:0] i);
    int unsigned imm = i % 65536;
    return (imm >= 32768) ? 32'(imm + 32'hFFFF_0000) : 32'(imm);
  endfunction
  function automatic logic [31:0] m_jt(input logic [31:0] i, input logic [31:0] pc);
    logic [31:0] pc4 = pc + 32'd4;
    return (pc4 & 32'hF000_0000) | ((i % 32'h0400_0000) * 4);
  endfunction

  // Monitor: checks handshake against queue occupancy and the head bundle
  initial begin
    item_t it;
    bit    exp_ready;
    while (!done) begin
      @(negedge clk);
      #2;
      exp_ready = SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || out_ready);
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        it = exp_q[0];
        check("opcode",   64'(out_opcode),   64'(m_op(it.instr)));
        check("rs",       64'(out_rs),       64'(m_fld(it.instr, 21)));
        check("rt",       64'(out_rt),       64'(m_fld(it.instr, 16)));
        check("rd",       64'(out_rd),       64'(m_fld(it.instr, 11)));
        check("shmt",     64'(out_shmt),     64'(m_fld(it.instr, 6)));
        check("func",     64'(out_func),     64'(it.instr % 64));
        check("fmt",      64'(out_fmt),      64'(m_fmt(it.instr)));
        check("dst",      64'(out_dst),      64'(m_dst(it.instr)));
        check("imm_sext", 64'(out_imm_sext), 64'(m_sext(it.instr)));
        check("imm_zext", 64'(out_imm_zext), 64'(it.instr % 65536));
        check("jtarget",  64'(out_jtarget),  64'(m_jt(it.instr, it.pc)));
        check("pc",       64'(out_pc),       64'(it.pc));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; expected accept decided from queue occupancy
  task automatic cycle(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    bit    acc;
    item_t it;
    @(negedge clk);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc = v && (SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || ordy));
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (acc) begin
      it.instr = instr;
      it.pc    = pc;
      exp_q.push_back(it);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  op;
    logic [25:0] lo;
    case ($urandom_range(0, 3))
      0:       op = 6'h00;
      1:       op = 6'h02;
      2:       op = 6'h03;
      default: op = 6'($urandom_range(0, 63));
    endcase
    lo = 26'($urandom);
    return {op, lo};
  endfunction

  initial begin
    logic [31:0] pc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #12;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready",  64'(in_ready),  64'd1);
    check("rst out_pc",    64'(out_pc),    64'(RST_PC));
    check("rst out_fmt",   64'(out_fmt),   64'd0);
    check("rst out_dst",   64'(out_dst),   64'd0);
    check("rst jtarget",   64'(out_jtarget), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add $8,$9,$10
    cycle(1'b1, 32'h012A_4020, 32'h0040_0000, 1'b1, 1'b0);
    #1;
    check("add rs", 64'(out_rs), 64'd9);
    check("add rt", 64'(out_rt), 64'd10);
    check("add rd", 64'(out_rd), 64'd8);
    check("add func", 64'(out_func), 64'h20);
    check("add fmt", 64'(out_fmt), 64'd0);
    check("add dst", 64'(out_dst), 64'd8);

    // addi with negative immediate
    cycle(1'b1, 32'h2109_FFFF, 32'h0040_0004, 1'b1, 1'b0);
    #1;
    check("addi sext", 64'(out_imm_sext), 64'hFFFF_FFFF);
    check("addi zext", 64'(out_imm_zext), 64'h0000_FFFF);
    check("addi fmt", 64'(out_fmt), 64'd2);
    check("addi dst", 64'(out_dst), 64'd9);

    // jal across a jump-region boundary
    cycle(1'b1, 32'h0C10_0000, 32'h3FFF_FFFC, 1'b1, 1'b0);
    #1;
    check("jal jtarget", 64'(out_jtarget), 64'h4040_0000);
    check("jal fmt", 64'(out_fmt), 64'd1);
    check("jal dst", 64'(out_dst), 64'd31);

    // j with PC+4 wrapping to zero
    cycle(1'b1, 32'h0800_0001, 32'hFFFF_FFFC, 1'b1, 1'b0);
    #1;
    check("j wrap jtarget", 64'(out_jtarget), 64'h0000_0004);
    check("j dst", 64'(out_dst), 64'd0);

    // Back-pressure: five held cycles, then release and drain
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 32'h2000_0000 + 32'(k), 32'h0000_1000 + 32'(4 * k), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush together with an accept while FULL
    cycle(1'b1, 32'h3C01_1234, 32'h0000_2000, 1'b0, 1'b0);
    cycle(1'b1, 32'h3C02_5678, 32'h0000_2004, 1'b0, 1'b1);
    #1;
    check("flush out_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 2; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      cycle($urandom_range(0, 9) < 7, rand_instr(), pc,
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset while a bundle is held
    cycle(1'b1, 32'h0000_0000, 32'h0000_3000, 1'b1, 1'b0);
    cycle(1'b1, 32'h2003_0001, 32'h0000_3004, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    #3;
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset out_pc", 64'(out_pc), 64'(RST_PC));
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    for (int k = 0; k < 20; k++)
      cycle($urandom_range(0, 1) == 1, rand_instr(), $urandom & 32'hFFFF_FFFC, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    done = 1'b1;
    @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised MIPS instruction-decode pipeline stage between instruction fetch and the control unit / register file. Accepts a fetched 32-bit instruction plus its PC over a valid/ready handshake and splits it into fields. It also classifies the format (R/I/J), derives the destination register, and builds sign/zero-extended immediates and the absolute jump target at XLEN width. Output is held stable under back-pressure, and the stage can be flushed on a taken branch or jump.

## Interface
- XLEN, 32: datapath/PC width. Legal range 32..64. Sets the width of immediates, PC and jump target.
- RESET_PC, 0: value driven on out_pc while no instruction has ever been loaded.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  discard the held instruction and any input accepted this cycle
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept this cycle
- in_instr  input  32  instruction word
- in_pc  input  XLEN  address of in_instr
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  downstream accepts bundle
- out_opcode  output  6  instr[31:26]
- out_rs, out_rt, out_rd, out_shmt  output  5 each  instr[25:21], [20:16], [15:11], [10:6]
- out_func  output  6  instr[5:0]
- out_imm_sext  output  XLEN  instr[15:0] sign-extended
- out_imm_zext  output  XLEN  instr[15:0] zero-extended
- out_jtarget  output  XLEN  {pc4[XLEN-1:28], instr[25:0], 2'b00}, where pc4 = in_pc+4 (modulo 2^XLEN)
- out_fmt  output  2  0=R (opcode 0), 1=J (opcode 2 or 3), 2=I (all others); 3 is never driven
- out_dst  output  5  R: rd; I: rt; opcode 3 (jal): 31; opcode 2 (j): 0
- out_pc  output  XLEN  PC of held instruction

## Operation
- Accept occurs when in_valid && in_ready. Transfer occurs when out_valid && out_ready.
- Decode is fully combinational from in_instr and in_pc. All outputs are registered at accept and are not recomputed from later inputs.
- Base in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
- States:
  - EMPTY (out_valid=0): accept → FULL.
  - FULL with no transfer: hold every output bit-stable.
  - FULL with transfer and accept: reload, stay FULL.
  - FULL with transfer and no accept: → EMPTY.
- flush: out_valid and the skid entry are cleared on the next edge. A simultaneous accept is dropped. in_ready is unaffected by flush.
- Data registers are not cleared in EMPTY. Only out_valid qualifies them.
- Reset mid-operation: every valid bit clears immediately (asynchronous). The bundle in flight is lost.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle when out_ready=1.
- Reset values:
  - out_valid=0
  - all field, immediate and target outputs = 0
  - out_fmt=0
  - out_dst=0
  - out_pc=RESET_PC
  - in_ready=1 (base), 1 (skid)
- pc4 carry out of bit XLEN-1 is discarded (wrap-around).
- When XLEN=32, pc4[31:28] forms the jump region.

## Configuration
- DECODE_SKID_EN defined: adds a one-entry skid buffer.
  - in_ready becomes a register equal to "skid empty", so there is no combinational out_ready→in_ready path.
  - An accept while FULL with out_ready=0 lands in the skid entry. in_ready then drops on the next cycle.
  - On transfer, the skid entry moves to the output register before any new input.
  - Ordering is preserved. Full throughput is kept.
  - flush clears both entries.
- DECODE_SKID_EN undefined: single register, combinational in_ready as above.

## Structure
- Shared package decode_pkg:
  - format enum FMT_R=0, FMT_J=1, FMT_I=2
  - opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03
  - REG_RA=5'd31
  - decoded-bundle struct, parametrised via XLEN at use site
- Sub-module decode_fields: purely combinational field split, classification, out_dst and extension. decode_stage instantiates it and owns the handshake, skid and registers.

## Test plan
- Reset sequence (rst_n low mid-run, out_valid=1): out_valid drops immediately. After release, out_pc=RESET_PC and in_ready=1.
- Field split:
  - Stimulus: accept 0x012A4020 (add $8,$9,$10) with out_ready=1.
  - Response: next cycle rs=9, rt=10, rd=8, func=0x20, fmt=R, dst=8.
- Immediate extension and I-format:
  - Stimulus: accept 0x2109FFFF (addi), XLEN=32.
  - Response: imm_sext=0xFFFFFFFF, imm_zext=0x0000FFFF, fmt=I, dst=9.
- Jump target and jal:
  - Stimulus: accept 0x0C100000 (jal) at pc=0x3FFFFFFC.
  - Response: pc4=0x40000000, jtarget=0x40400000, fmt=J, dst=31.
- Back-pressure: hold out_ready=0 for 5 cycles while FULL.
  - Outputs are stable throughout.
  - Base: in_ready=0.
  - Skid: exactly one extra accept, then in_ready=0. On release, both instructions emerge in order on consecutive cycles.
- Flush:
  - Assert flush in the same cycle as an accept while FULL.
  - Next cycle: out_valid=0, and neither instruction ever appears.
